// File: rtl/mb_fetch_ctrl.sv
// Macroblock fetch controller: walks the 96 words of one 4:2:0 macroblock
// (64 Y, 16 U, 16 V) from memory and streams them into the plane buffers.
module mb_fetch_ctrl #(
   parameter int unsigned MB_W      = 22,
   parameter int unsigned MB_H      = 18,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  mb_x,
   input  logic [5:0]  mb_y,
   input  logic        data_valid,
   input  logic [31:0] data_word,
   output logic [31:0] fetch_addr,
   output logic        fetch_req,
   output logic        buf_we,
   output logic [1:0]  buf_sel,
   output logic [3:0]  buf_row,
   output logic [1:0]  buf_col,
   output logic [31:0] buf_wdata,
   output logic        busy,
   output logic        fetch_finish,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  sel;
      logic [3:0]  row;
      logic [1:0]  col;
      logic [31:0] wdata;
   } buf_wr_t;

   localparam logic [6:0]  LAST_WORD    = 7'd95;
   localparam logic [31:0] WORDS_PER_MB = 32'd96;

   state_e      state_q, state_d;
   logic [6:0]  wcnt_q, wcnt_d;
   logic [5:0]  mbx_q, mbx_d;
   logic [5:0]  mby_q, mby_d;
   logic        err_q, err_d;
   buf_wr_t     bw_q, bw_d;

   logic        in_range;
   logic        launch;
   logic        accept;
   logic [31:0] mb_idx;
   logic [31:0] addr;

   assign in_range = ({26'd0, mb_x} < MB_W) && ({26'd0, mb_y} < MB_H);
   assign launch   = (state_q == S_IDLE) && start && in_range;
   assign accept   = (state_q == S_FETCH) && data_valid;

   assign mb_idx = {26'd0, mby_q} * MB_W + {26'd0, mbx_q};
   assign addr   = BASE_ADDR + mb_idx * WORDS_PER_MB + {25'd0, wcnt_q};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_FETCH;
         S_FETCH: if (accept && (wcnt_q == LAST_WORD)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      fetch_req    = 1'b0;
      busy         = 1'b0;
      fetch_finish = 1'b0;
      fetch_addr   = '0;
      case (state_q)
         S_FETCH: begin
            fetch_req  = 1'b1;
            busy       = 1'b1;
            fetch_addr = addr;
         end
         // word 95's registered write lands in this same cycle
         S_DONE: begin
            busy         = 1'b1;
            fetch_finish = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- word counter / coordinates / error ----------------
   always_comb begin
      wcnt_d = wcnt_q;
      mbx_d  = mbx_q;
      mby_d  = mby_q;
      err_d  = (state_q == S_IDLE) && start && !in_range;
      if (launch) begin
         mbx_d  = mb_x;
         mby_d  = mb_y;
         wcnt_d = '0;
      end else if (accept) begin
         wcnt_d = wcnt_q + 7'd1;
      end
   end

   // ---------------- buffer write mapping ----------------
   // U starts at 64 and V at 80, both multiples of 16, so the chroma
   // offset's row/col bits are just wcnt[3:1] / wcnt[0].
   always_comb begin
      bw_d    = bw_q;
      bw_d.we = accept;
      if (accept) begin
         bw_d.wdata = data_word;
         if (wcnt_q < 7'd64) begin
            bw_d.sel = 2'd0;
            bw_d.row = wcnt_q[5:2];
            bw_d.col = wcnt_q[1:0];
         end else begin
            bw_d.sel = (wcnt_q < 7'd80) ? 2'd1 : 2'd2;
            bw_d.row = {1'b0, wcnt_q[3:1]};
            bw_d.col = {1'b0, wcnt_q[0]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q <= '0;
         mbx_q  <= '0;
         mby_q  <= '0;
         err_q  <= 1'b0;
         bw_q   <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         mbx_q  <= mbx_d;
         mby_q  <= mby_d;
         err_q  <= err_d;
         bw_q   <= bw_d;
      end
   end

   assign err       = err_q;
   assign buf_we    = bw_q.we;
   assign buf_sel   = bw_q.sel;
   assign buf_row   = bw_q.row;
   assign buf_col   = bw_q.col;
   assign buf_wdata = bw_q.wdata;

endmodule

// File: tb/tb_mb_fetch_ctrl.sv
// Directed bench for mb_fetch_ctrl: full macroblock walks, stall, ignored
// start, range errors, and mid-fetch reset.
module tb_mb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        data_valid = 1'b0;
   logic [5:0]  mb_x = 6'd0;
   logic [5:0]  mb_y = 6'd0;
   logic [31:0] data_word, fetch_addr, buf_wdata;
   logic        fetch_req, buf_we, busy, fetch_finish, err;
   logic [1:0]  buf_sel, buf_col;
   logic [3:0]  buf_row;

   int n_cmp = 0;
   int n_bad = 0;

   mb_fetch_ctrl #(.MB_W(22), .MB_H(18), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .mb_x(mb_x), .mb_y(mb_y),
      .data_valid(data_valid), .data_word(data_word),
      .fetch_addr(fetch_addr), .fetch_req(fetch_req),
      .buf_we(buf_we), .buf_sel(buf_sel), .buf_row(buf_row), .buf_col(buf_col),
      .buf_wdata(buf_wdata), .busy(busy), .fetch_finish(fetch_finish), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign data_word = pat(fetch_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // expected {sel,row,col,wdata} for the n-th buffer write of a macroblock
   function automatic logic [39:0] exp_wr(input int n, input logic [31:0] base);
      logic [1:0] s;
      logic [3:0] r;
      logic [1:0] cl;
      int         o;
      if (n < 64) begin
         s = 2'd0; o = n;
         r = 4'(o / 4); cl = 2'(o % 4);
      end else begin
         s = (n < 80) ? 2'd1 : 2'd2;
         o = n - ((n < 80) ? 64 : 80);
         r = 4'(o / 2); cl = 2'(o % 2);
      end
      return {s, r, cl, pat(base + 32'(n))};
   endfunction

   task automatic chk_zero_outs(input string tg);
      chk({tg, "_addr"}, fetch_addr, 32'd0);
      chk({tg, "_ctl"}, {27'd0, fetch_req, buf_we, busy, fetch_finish, err}, 32'd0);
      chk({tg, "_buf"}, {24'd0, buf_sel, buf_row, buf_col}, 32'd0);
      chk({tg, "_wdata"}, buf_wdata, 32'd0);
   endtask

   task automatic run_mb(input string tg, input logic [5:0] x, input logic [5:0] y,
                         input int stall_len, input bit poke);
      logic [31:0] base, first_a, last_a;
      int  acc, nwr, fin, n_y, n_u, n_v, seq_err, map_err, stall_we, busy_err, stalled;
      bit  prev_stall, cur_stall;
      base = (32'(y) * 32'd22 + 32'(x)) * 32'd96;
      acc = 0; nwr = 0; fin = -1; n_y = 0; n_u = 0; n_v = 0;
      seq_err = 0; map_err = 0; stall_we = 0; busy_err = 0; stalled = 0;
      prev_stall = 1'b0; first_a = '1; last_a = '1;
      @(posedge clk); #1;
      mb_x = x; mb_y = y; start = 1'b1; data_valid = 1'b1;
      @(negedge clk);
      chk({tg, "_idle"}, {30'd0, busy, fetch_req}, 32'd0);
      @(posedge clk); #1;
      for (int c = 1; c <= 300; c++) begin
         start = 1'b0;
         if (poke && c == 20) begin
            mb_x = 6'd3; mb_y = 6'd4; start = 1'b1;
         end
         cur_stall  = (acc == 10) && (stalled < stall_len);
         data_valid = !cur_stall;
         @(negedge clk);
         if (!busy) busy_err++;
         if (fetch_req) begin
            if (fetch_addr !== base + 32'(acc)) seq_err++;
            if (acc == 0)  first_a = fetch_addr;
            if (acc == 95) last_a  = fetch_addr;
         end
         if (buf_we) begin
            if (prev_stall) stall_we++;
            case (buf_sel)
               2'd0:    n_y++;
               2'd1:    n_u++;
               default: n_v++;
            endcase
            if ({buf_sel, buf_row, buf_col, buf_wdata} !== exp_wr(nwr, base)) map_err++;
            nwr++;
         end
         if (fetch_finish) fin = c;
         if (fetch_req && data_valid) acc++;
         if (cur_stall) stalled++;
         prev_stall = cur_stall;
         if (fin >= 0) break;
         @(posedge clk); #1;
      end
      chk({tg, "_first"}, first_a, base);
      chk({tg, "_last"}, last_a, base + 32'd95);
      chk({tg, "_fin_cyc"}, fin, 97 + stall_len);
      chk({tg, "_n_y"}, n_y, 64);
      chk({tg, "_n_u"}, n_u, 16);
      chk({tg, "_n_v"}, n_v, 16);
      chk({tg, "_addr_seq"}, seq_err, 0);
      chk({tg, "_wr_map"}, map_err, 0);
      chk({tg, "_busy"}, busy_err, 0);
      if (stall_len > 0) chk({tg, "_stall_we"}, stall_we, 0);
   endtask

   task automatic err_case(input string tg, input logic [5:0] x, input logic [5:0] y);
      @(posedge clk); #1;
      mb_x = x; mb_y = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({tg, "_pulse"}, {31'd0, err}, 32'd1);
      chk({tg, "_busy_req"}, {30'd0, busy, fetch_req}, 32'd0);
      @(negedge clk);
      chk({tg, "_clear"}, {29'd0, err, busy, fetch_req}, 32'd0);
   endtask

   initial begin
      int fin_cnt, busy_cnt;
      #2 rst = 1'b0;
      #1 chk_zero_outs("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      run_mb("a", 6'd0, 6'd0, 0, 1'b0);
      run_mb("b", 6'd1, 6'd2, 0, 1'b0);   // back-to-back after "a"
      run_mb("stall", 6'd0, 6'd0, 3, 1'b0);
      run_mb("poke", 6'd0, 6'd0, 0, 1'b1);
      run_mb("corner", 6'd21, 6'd17, 0, 1'b0);
      err_case("err_x", 6'd22, 6'd0);
      err_case("err_y", 6'd0, 6'd18);

      // reset in the middle of a fetch
      @(posedge clk); #1;
      mb_x = 6'd0; mb_y = 6'd0; start = 1'b1; data_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (50) @(posedge clk);
      #1 chk("pre_rst_addr", fetch_addr, 32'd50);
      rst = 1'b0;
      #1 chk_zero_outs("mid_rst");
      fin_cnt = 0; busy_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         fin_cnt += int'(fetch_finish);
      end
      @(posedge clk); #1 rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         fin_cnt  += int'(fetch_finish);
         busy_cnt += int'(busy);
      end
      chk("rst_no_fin", fin_cnt, 0);
      chk("rst_stays_idle", busy_cnt, 0);
      run_mb("after_rst", 6'd0, 6'd0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
